jk_bank_driver: RTL and testbench

Sequencing controller that drives a bank of WIDTH negative-edge JK flip-flops, which share clk and reset with this block. The block runs on the rising edge and walks the bank through a count-up, count-down or load sequence. For each step it derives the J/K excitation from the current and target state, pulses the bank enable for one cycle, and reads Q back on the next rising edge to confirm the transition. It sits beside the flip-flop bank as its excitation source and self-checker.

---
 rtl/jk_drv_pkg.sv | 29 ++
 rtl/jk_bank_driver_excite.sv | 21 ++
 rtl/jk_bank_driver.sv | 162 ++++++++++++++++
 tb/tb_jk_bank_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and encodings for the JK bank sequencing controller.
// Excitation constants are packed as {J, K}.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] EXC_HOLD   = 2'b00;
  localparam logic [1:0] EXC_RESET  = 2'b01;
  localparam logic [1:0] EXC_SET    = 2'b10;
  localparam logic [1:0] EXC_TOGGLE = 2'b11;

  // Steady bits never need drive; changing bits use set/reset or toggle.
  function automatic logic [1:0] excite(input logic cur, input logic nxt, input logic tog);
    if (cur == nxt) return EXC_HOLD;
    if (tog) return EXC_TOGGLE;
    return nxt ? EXC_SET : EXC_RESET;
  endfunction

endpackage

// File: rtl/jk_bank_driver_excite.sv
// Combinational J/K excitation for a vector of JK flip-flops,
// mapping current and target state bit-by-bit.
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int USE_TOGGLE = 0
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] nxt_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  localparam logic TOG = (USE_TOGGLE != 0);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j_o[i], k_o[i]} = excite(cur_i[i], nxt_i[i], TOG);
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Excitation source and self-checker for a negedge JK flip-flop bank.
// Steps are launched on posedge, land at the mid-cycle negedge, verified next posedge.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; expected/step_cnt hold last verified values
// ST_DRIVE | en_out high one cycle with J/K for the registered target
// ST_CHECK | drives released; q_in compared against target at cycle end
// ST_ERROR | readback disagreed; drives off, mismatch held until restart
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int USE_TOGGLE = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             en_out,
  output logic             busy,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic [CNT_W-1:0] step_cnt
);

  state_e           state_q;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] base_d;
  logic [WIDTH-1:0] j_q, k_q, exc_j, exc_k;
  logic             en_q, busy_q, mismatch_q;
  logic [CNT_W-1:0] cnt_q;
  logic             match, single_step, launch;

  assign match       = (q_in == target_q);
  assign single_step = stop || (mode_q == MODE_LOAD) || (mode_q == MODE_HOLD);

  // The next step is computed from the state the bank will be in when it is
  // launched: last verified value, the value just verified, or a resync from q_in.
  always_comb begin
    base_d = expected_q;
    mode_d = mode_q;
    load_d = load_q;
    launch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mode_d = mode;
        load_d = load_val;
        launch = start;
      end
      ST_CHECK: begin
        base_d = target_q;
        launch = match && !single_step;
      end
      ST_ERROR: begin
        base_d = q_in;
        mode_d = mode;
        load_d = load_val;
        launch = start;
      end
      default: ;
    endcase

    case (mode_d)
      MODE_UP:   target_d = base_d + WIDTH'(1);
      MODE_DOWN: target_d = base_d - WIDTH'(1);
      MODE_LOAD: target_d = load_d;
      default:   target_d = base_d;
    endcase
  end

  jk_excite #(
    .WIDTH      (WIDTH),
    .USE_TOGGLE (USE_TOGGLE)
  ) u_excite (
    .cur_i (base_d),
    .nxt_i (target_d),
    .j_o   (exc_j),
    .k_o   (exc_k)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_HOLD;
      load_q     <= '0;
      target_q   <= '0;
      expected_q <= '0;
      j_q        <= '0;
      k_q        <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      j_q  <= '0;
      k_q  <= '0;
      en_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= mode_d;
            load_q     <= load_d;
            mismatch_q <= 1'b0;
          end
        end
        ST_DRIVE: state_q <= ST_CHECK;
        ST_CHECK: begin
          if (match) begin
            expected_q <= target_q;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (single_step) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            mismatch_q <= 1'b1;
            state_q    <= ST_ERROR;
            busy_q     <= 1'b0;
          end
        end
        ST_ERROR: begin
          if (start) begin
            expected_q <= q_in;
            mode_q     <= mode_d;
            load_q     <= load_d;
            mismatch_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (launch) begin
        state_q  <= ST_DRIVE;
        target_q <= target_d;
        j_q      <= exc_j;
        k_q      <= exc_k;
        en_q     <= 1'b1;
        busy_q   <= 1'b1;
      end
    end
  end

  assign j_out    = j_q;
  assign k_out    = k_q;
  assign en_out   = en_q;
  assign busy     = busy_q;
  assign expected = expected_q;
  assign mismatch = mismatch_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench: two drivers (set/reset and toggle encoding) each steering
// its own negedge JK bank model, with a stuck-at mask on the first bank's readback.
module tb_jk_bank_driver;
  import jk_drv_pkg::*;

  logic       clk, reset, start, stop;
  logic [1:0] mode;
  logic [3:0] load_val, fault_mask;
  logic [3:0] bank_a, bank_b, q_in_a;
  logic [3:0] j_a, k_a, exp_a, j_b, k_b, exp_b;
  logic       en_a, busy_a, mis_a, en_b, busy_b, mis_b;
  logic [15:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;

  jk_bank_driver #(.WIDTH(4), .USE_TOGGLE(0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .load_val(load_val), .q_in(q_in_a), .j_out(j_a), .k_out(k_a),
    .en_out(en_a), .busy(busy_a), .expected(exp_a), .mismatch(mis_a),
    .step_cnt(cnt_a)
  );

  jk_bank_driver #(.WIDTH(4), .USE_TOGGLE(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .load_val(load_val), .q_in(bank_b), .j_out(j_b), .k_out(k_b),
    .en_out(en_b), .busy(busy_b), .expected(exp_b), .mismatch(mis_b),
    .step_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK characteristic equation: Q+ = J&~Q | ~K&Q
  always @(negedge clk or posedge reset) begin
    if (reset) bank_a <= 4'h0;
    else if (en_a) bank_a <= (j_a & ~bank_a) | (~k_a & bank_a);
  end
  always @(negedge clk or posedge reset) begin
    if (reset) bank_b <= 4'h0;
    else if (en_b) bank_b <= (j_b & ~bank_b) | (~k_b & bank_b);
  end
  assign q_in_a = bank_a & ~fault_mask;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = MODE_HOLD;
    load_val = 4'h0; fault_mask = 4'h0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_expected", 32'(exp_a), 32'h0);
    chk("rst_step_cnt", 32'(cnt_a), 32'h0);
    chk("rst_mismatch", 32'(mis_a), 32'h0);
    chk("rst_en",       32'(en_a), 32'h0);
    chk("rst_busy",     32'(busy_a), 32'h0);
    chk("rst_jk",       32'({j_a, k_a}), 32'h0);
    chk("rst_state",    32'(dut_a.state_q), 32'(ST_IDLE));

    // Up run: 17 steps with wrap, stop raised during the last DRIVE
    mode = MODE_UP; start = 1'b1;
    step();
    start = 1'b0;
    chk("up_first_j", 32'(j_a), 32'h1);
    for (int i = 1; i <= 17; i++) begin
      chk("up_en_drive", 32'(en_a), 32'h1);
      if (i == 17) stop = 1'b1;
      step();
      chk("up_en_check", 32'(en_a), 32'h0);
      chk("up_busy_check", 32'(busy_a), 32'h1);
      step();
      chk("up_expected", 32'(exp_a), 32'(i % 16));
      chk("up_step_cnt", 32'(cnt_a), 32'(i));
    end
    chk("up_mismatch", 32'(mis_a), 32'h0);
    chk("up_end_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    chk("up_end_busy", 32'(busy_a), 32'h0);
    chk("up_end_en", 32'(en_a), 32'h0);
    stop = 1'b0;

    // Down from 0 wraps to F
    do_reset();
    mode = MODE_DOWN; start = 1'b1;
    step();
    start = 1'b0;
    chk("down_j_a", 32'(j_a), 32'hF);
    chk("down_k_a", 32'(k_a), 32'h0);
    chk("down_j_b", 32'(j_b), 32'hF);
    chk("down_k_b", 32'(k_b), 32'hF);
    stop = 1'b1;
    step(); step();
    chk("down_expected", 32'(exp_a), 32'hF);
    chk("down_bank", 32'(bank_a), 32'hF);
    chk("down_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    chk("down_step_cnt", 32'(cnt_a), 32'h1);
    stop = 1'b0;

    // Load 5 -> A: toggle encoding drives all bits J1K1
    do_reset();
    stop = 1'b1; mode = MODE_UP;
    for (int n = 0; n < 5; n++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
    end
    chk("load_pre_expected", 32'(exp_b), 32'h5);
    stop = 1'b0; mode = MODE_LOAD; load_val = 4'hA; start = 1'b1;
    step();
    start = 1'b0;
    chk("load_j_b", 32'(j_b), 32'hF);
    chk("load_k_b", 32'(k_b), 32'hF);
    chk("load_j_a", 32'(j_a), 32'hA);
    chk("load_k_a", 32'(k_a), 32'h5);
    step(); step();
    chk("load_expected", 32'(exp_b), 32'hA);
    chk("load_step_cnt", 32'(cnt_b), 32'h6);
    chk("load_state", 32'(dut_b.state_q), 32'(ST_IDLE));
    chk("load_busy", 32'(busy_b), 32'h0);

    // Readback bit0 stuck at 0 during an up step from 0
    do_reset();
    fault_mask = 4'h1; mode = MODE_UP; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("fault_mismatch", 32'(mis_a), 32'h1);
    chk("fault_state", 32'(dut_a.state_q), 32'(ST_ERROR));
    chk("fault_expected", 32'(exp_a), 32'h0);
    chk("fault_step_cnt", 32'(cnt_a), 32'h0);
    step();
    chk("fault_hold_en", 32'(en_a), 32'h0);
    chk("fault_hold_mis", 32'(mis_a), 32'h1);
    fault_mask = 4'h0; stop = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("resync_mismatch", 32'(mis_a), 32'h0);
    chk("resync_expected", 32'(exp_a), 32'h1);
    chk("resync_state", 32'(dut_a.state_q), 32'(ST_DRIVE));
    chk("resync_jk", 32'({j_a, k_a}), 32'h21);
    step(); step();
    chk("resync_done_exp", 32'(exp_a), 32'h2);
    chk("resync_done_cnt", 32'(cnt_a), 32'h1);
    chk("resync_done_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    stop = 1'b0;

    // Reset asserted during DRIVE
    do_reset();
    mode = MODE_UP; start = 1'b1;
    step();
    start = 1'b0;
    chk("midrst_en_before", 32'(en_a), 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_en", 32'(en_a), 32'h0);
    chk("midrst_busy", 32'(busy_a), 32'h0);
    chk("midrst_jk", 32'({j_a, k_a}), 32'h0);
    chk("midrst_expected", 32'(exp_a), 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("midrst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    chk("midrst_after_exp", 32'(exp_a), 32'h0);
    chk("midrst_bank", 32'(bank_a), 32'h0);
    chk("midrst_cnt", 32'(cnt_a), 32'h0);

    // start with mode=load pulsed during CHECK is ignored
    do_reset();
    mode = MODE_UP; start = 1'b1;
    step();
    start = 1'b0;
    step();
    mode = MODE_LOAD; load_val = 4'h3; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_exp", 32'(exp_a), 32'h1);
    chk("busy_start_state", 32'(dut_a.state_q), 32'(ST_DRIVE));
    chk("busy_start_jk", 32'({j_a, k_a}), 32'h21);
    step(); step();
    chk("busy_start_exp2", 32'(exp_a), 32'h2);
    chk("busy_start_state2", 32'(dut_a.state_q), 32'(ST_DRIVE));
    stop = 1'b1;
    step(); step();
    chk("busy_start_exp3", 32'(exp_a), 32'h3);
    chk("busy_start_cnt", 32'(cnt_a), 32'h3);
    chk("busy_start_idle", 32'(dut_a.state_q), 32'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
